// File: rtl/timer_entry_ctrl.sv
// rtl/timer_entry_ctrl.sv - keypad entry and cook sequencing for the microwave countdown timer
//
// Purpose:
//   Collects BCD key presses into a 3-digit entry (M:S S), validates it on
//   start, parallel-loads it into the downstream counter chain and then
//   sequences cooking, pausing and completion.
//
// Ports:
//   clk          in   system clock, rising edge
//   clrn         in   asynchronous active-low reset
//   key[3:0]     in   keypad code, qualified by key_valid
//   key_valid    in   one-cycle strobe per key press
//   start        in   start/resume request (level)
//   stop_clear   in   stop/clear request (level)
//   door_closed  in   1 = door closed
//   zero         in   counter chain reads 0:00
//   mins_data    out  minutes digit to the counter chain
//   tens_data    out  seconds-tens digit to the counter chain
//   ones_data    out  seconds-ones digit to the counter chain
//   loadn        out  active-low parallel load to all counter digits
//   en           out  count enable to the chain
//   mag_on       out  magnetron drive
//   done         out  cook complete
//   err          out  entry rejected at start

module timer_entry_ctrl #(
  parameter int MAX_TENS    = 5,
  parameter int KEY_BAD_MIN = 10
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] mins_data,
  output logic [3:0] tens_data,
  output logic [3:0] ones_data,
  output logic       loadn,
  output logic       en,
  output logic       mag_on,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mins_q, mins_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       loadn_q, loadn_d;
  logic       en_q, en_d;
  logic       mag_on_q, mag_on_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic key_ok;
  logic entry_zero;
  logic tens_bad;

  assign key_ok     = key_valid && (int'(key) < KEY_BAD_MIN);
  assign entry_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign tens_bad   = int'(tens_q) > MAX_TENS;

  always_comb begin
    state_d = state_q;
    mins_d  = mins_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    err_d   = err_q;

    case (state_q)
      // Entry states. In IDLE the entry is already 0:00, so treating
      // stop_clear the same way as in SET is harmless and keeps the
      // priority order uniform (it also swallows a same-cycle key).
      S_IDLE, S_SET: begin
        if (stop_clear) begin
          state_d = S_IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          err_d   = 1'b0;
        end else if (state_q == S_SET && start) begin
          // start always consumes the cycle in SET, so a coincident key is
          // dropped even when the start itself is refused. An open door
          // outranks start, so nothing at all happens then.
          if (door_closed) begin
            if (tens_bad) begin
              err_d = 1'b1;
            end else if (!entry_zero) begin
              state_d = S_LOAD;
            end
          end
        end else if (key_ok) begin
          mins_d  = tens_q;
          tens_d  = ones_q;
          ones_d  = key;
          err_d   = 1'b0;
          state_d = S_SET;
        end
      end

      S_LOAD: state_d = S_COOK;

      S_COOK: begin
        if (stop_clear || !door_closed) begin
          state_d = S_PAUSE;
        end else if (zero) begin
          state_d = S_DONE;
        end
      end

      S_PAUSE: begin
        if (stop_clear) begin
          state_d = S_IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          err_d   = 1'b0;
        end else if (start && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        if (stop_clear || !door_closed) begin
          state_d = S_IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered versions
    // change on the same edge as the state itself.
    loadn_d  = (state_d != S_LOAD);
    en_d     = (state_d == S_COOK);
    mag_on_d = (state_d == S_COOK);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      mins_q   <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      loadn_q  <= 1'b1;
      en_q     <= 1'b0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mins_q   <= mins_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      loadn_q  <= loadn_d;
      en_q     <= en_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mins_data = mins_q;
  assign tens_data = tens_q;
  assign ones_data = ones_q;
  assign loadn     = loadn_q;
  assign en        = en_q;
  assign mag_on    = mag_on_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// tb/tb_timer_entry_ctrl.sv - self-checking bench for timer_entry_ctrl
//
// Purpose:
//   Directed vector table, a hand-written reset-during-cook sequence and
//   randomized stimulus against a behavioural model of the timer controller.
//
// Ports: none (top-level bench).

module tb_timer_entry_ctrl;

  localparam int MAX_TENS    = 5;
  localparam int KEY_BAD_MIN = 10;

  logic       clk;
  logic       clrn;
  logic [3:0] key;
  logic       key_valid;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       zero;
  logic [3:0] mins_data;
  logic [3:0] tens_data;
  logic [3:0] ones_data;
  logic       loadn;
  logic       en;
  logic       mag_on;
  logic       done;
  logic       err;

  int n_vec;
  int n_bad;

  timer_entry_ctrl #(
    .MAX_TENS   (MAX_TENS),
    .KEY_BAD_MIN(KEY_BAD_MIN)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .key        (key),
    .key_valid  (key_valid),
    .start      (start),
    .stop_clear (stop_clear),
    .door_closed(door_closed),
    .zero       (zero),
    .mins_data  (mins_data),
    .tens_data  (tens_data),
    .ones_data  (ones_data),
    .loadn      (loadn),
    .en         (en),
    .mag_on     (mag_on),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic       kv, st, sc, dr, zr;
    logic [3:0] m, t, o;
    logic       ln, en, mg, dn, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int k, input int kv, input int st, input int sc,
                             input int dr, input int zr, input int m, input int t,
                             input int o, input int ln, input int en_e, input int mg,
                             input int dn, input int er);
    vec_t r;
    r.key = 4'(k);  r.kv = 1'(kv); r.st = 1'(st); r.sc = 1'(sc);
    r.dr  = 1'(dr); r.zr = 1'(zr);
    r.m   = 4'(m);  r.t  = 4'(t);  r.o  = 4'(o);
    r.ln  = 1'(ln); r.en = 1'(en_e); r.mg = 1'(mg); r.dn = 1'(dn); r.er = 1'(er);
    return r;
  endfunction

  task automatic compare(input string tag, input logic [3:0] m, input logic [3:0] t,
                         input logic [3:0] o, input logic ln, input logic en_e,
                         input logic mg, input logic dn, input logic er);
    logic [16:0] act, expv;
    act  = {mins_data, tens_data, ones_data, loadn, en, mag_on, done, err};
    expv = {m, t, o, ln, en_e, mg, dn, er};
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got m/t/o=%h/%h/%h loadn=%b en=%b mag=%b done=%b err=%b, want m/t/o=%h/%h/%h loadn=%b en=%b mag=%b done=%b err=%b",
               tag, mins_data, tens_data, ones_data, loadn, en, mag_on, done, err,
               m, t, o, ln, en_e, mg, dn, er);
    end
  endtask

  // Behavioural model: entry kept as a decimal number 0..999, mode by name.
  localparam int M_IDLE = 0, M_SET = 1, M_LOAD = 2, M_COOK = 3, M_PAUSE = 4, M_DONE = 5;
  int m_mode;
  int m_val;
  bit m_err;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_val  = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input int k, input bit kv, input bit st, input bit sc,
                            input bit dr, input bit zr);
    case (m_mode)
      M_IDLE, M_SET: begin
        if (sc) begin
          m_mode = M_IDLE; m_val = 0; m_err = 0;
        end else if (m_mode == M_SET && st) begin
          if (dr) begin
            if ((m_val / 10) % 10 > MAX_TENS) m_err = 1;
            else if (m_val != 0) m_mode = M_LOAD;
          end
        end else if (kv && k < KEY_BAD_MIN) begin
          m_val  = (m_val % 100) * 10 + k;
          m_mode = M_SET;
          m_err  = 0;
        end
      end
      M_LOAD: m_mode = M_COOK;
      M_COOK: begin
        if (sc || !dr) m_mode = M_PAUSE;
        else if (zr) m_mode = M_DONE;
      end
      M_PAUSE: begin
        if (sc) begin
          m_mode = M_IDLE; m_val = 0; m_err = 0;
        end else if (st && dr) m_mode = M_COOK;
      end
      default: begin
        if (sc || !dr) begin
          m_mode = M_IDLE; m_val = 0; m_err = 0;
        end
      end
    endcase
  endtask

  task automatic model_compare(input int i);
    compare($sformatf("rand[%0d]", i), 4'(m_val / 100), 4'((m_val / 10) % 10),
            4'(m_val % 10), m_mode != M_LOAD, m_mode == M_COOK, m_mode == M_COOK,
            m_mode == M_DONE, m_err);
  endtask

  task automatic idle_inputs();
    key = 4'd0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
    door_closed = 1'b1; zero = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clrn  = 1'b0;
    idle_inputs();

    //        key kv st sc dr zr  m t o ln en mg dn er
    // Entry 1:30 and start
    tbl.push_back(v(1, 1, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 1, 0,  0, 1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0,  1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  1, 3, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  1, 3, 0, 1, 1, 1, 0, 0));
    // Pause on door open, resume without reload
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  1, 3, 0, 1, 1, 1, 0, 0));
    // stop_clear beats zero in COOK, then clears from PAUSE
    tbl.push_back(v(0, 0, 0, 1, 1, 1,  1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    // Invalid tens 0:75
    tbl.push_back(v(0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(7, 1, 0, 0, 1, 0,  0, 0, 7, 1, 0, 0, 0, 0));
    tbl.push_back(v(5, 1, 0, 0, 1, 0,  0, 7, 5, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  0, 7, 5, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 7, 5, 1, 0, 0, 0, 1));
    tbl.push_back(v(2, 1, 0, 0, 1, 0,  7, 5, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(12, 1, 0, 0, 1, 0, 7, 5, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    // Completion from 0:05
    tbl.push_back(v(0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(5, 1, 0, 0, 1, 0,  0, 0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 5, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1,  0, 0, 5, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 5, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    // start in IDLE ignored; zero entry start ignored in SET
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    // key with start: key dropped (door open, then closed)
    tbl.push_back(v(9, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(2, 1, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    // Entry overflow
    tbl.push_back(v(1, 1, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(2, 1, 0, 0, 1, 0,  0, 1, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 1, 0,  1, 2, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(4, 1, 0, 0, 1, 0,  2, 3, 4, 1, 0, 0, 0, 0));
    // DONE left by door opening
    tbl.push_back(v(0, 0, 1, 0, 1, 0,  2, 3, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1,  2, 3, 4, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1,  2, 3, 4, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));

    #12;
    compare("reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      key = tbl[i].key; key_valid = tbl[i].kv; start = tbl[i].st;
      stop_clear = tbl[i].sc; door_closed = tbl[i].dr; zero = tbl[i].zr;
      @(posedge clk);
      #1;
      compare($sformatf("vec[%0d]", i), tbl[i].m, tbl[i].t, tbl[i].o, tbl[i].ln,
              tbl[i].en, tbl[i].mg, tbl[i].dn, tbl[i].er);
    end

    // Reset during COOK: outputs return to reset values without a clock edge.
    @(negedge clk); idle_inputs(); key = 4'd1; key_valid = 1'b1;
    @(negedge clk); idle_inputs(); start = 1'b1;
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    compare("cook_before_reset", 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 clrn = 1'b0;
    #1;
    compare("async_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clrn  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    compare("start_after_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    compare("idle_after_reset", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the model.
    @(negedge clk); clrn = 1'b0;
    @(negedge clk); clrn = 1'b1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      key         = 4'($urandom_range(0, 15));
      key_valid   = ($urandom_range(0, 99) < 35);
      start       = ($urandom_range(0, 99) < 25);
      stop_clear  = ($urandom_range(0, 99) < 6);
      door_closed = ($urandom_range(0, 99) < 88);
      zero        = ($urandom_range(0, 99) < 12);
      model_step(int'(key), key_valid, start, stop_clear, door_closed, zero);
      @(posedge clk); #1;
      model_compare(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
